// File: rtl/n2_ifft_butterfly_pkg.sv
// Shared FFT package: butterfly state encoding, default core latencies,
// float32 constants and the arithmetic functions used by the float cores.
package n2_ifft_butterfly_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SD,
      WAIT_SD,
      MUL2,
      WAIT_MUL,
      COMB2,
      WAIT_COMB
   } state_t;

   localparam int DEF_ADD_LAT = 12;
   localparam int DEF_MUL_LAT = 8;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_HALF = 32'h3F00_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   // Round to nearest even and pack; mant carries the hidden bit at [23].
   // Results below the normal range flush to a signed zero.
   function automatic logic [31:0] fp_round_pack(input logic s, input int e,
                                                 input logic [23:0] mant,
                                                 input logic g, input logic st);
      logic [24:0] r;
      int          ee;
      r  = {1'b0, mant} + (((g & (st | mant[0])) != 1'b0) ? 25'd1 : 25'd0);
      ee = e;
      if (r[24]) begin
         r  = r >> 1;
         ee = ee + 1;
      end
      if (ee >= 255)
         return {s, 8'hFF, 23'd0};
      else if (ee <= 0)
         return {s, 31'd0};
      else
         return {s, ee[7:0], r[22:0]};
   endfunction

   // float32 a + b; subnormal operands are treated as zero.
   function automatic logic [31:0] fp_add_f(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, my, mask;
      logic [27:0] m;
      logic [7:0]  d;
      logic        sticky;
      int          e;
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
         return FP_QNAN;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
         return (a[31] != b[31]) ? FP_QNAN : a;
      if (a[30:23] == 8'hFF) return a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
      if (a[30:23] == 8'd0) return b;
      if (b[30:23] == 8'd0) return a;
      // order so that |x| >= |y|
      if (b[30:0] > a[30:0]) begin
         x = b;
         y = a;
      end else begin
         x = a;
         y = b;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      if (d > 8'd26) begin
         sticky = 1'b1;
         my     = 27'd0;
      end else begin
         mask   = (27'd1 << d) - 27'd1;
         sticky = |(my & mask);
         my     = my >> d;
      end
      my[0] = my[0] | sticky;
      e     = int'(x[30:23]);
      if (x[31] == y[31]) begin
         m = {1'b0, mx} + {1'b0, my};
         if (m[27]) begin
            m = {1'b0, m[27:2], m[1] | m[0]};
            e = e + 1;
         end
      end else begin
         m = {1'b0, mx} - {1'b0, my};
         if (m == 28'd0) return FP_ZERO;
         for (int i = 0; i < 26; i++) begin
            if (!m[26]) begin
               m = m << 1;
               e = e - 1;
            end
         end
      end
      return fp_round_pack(x[31], e, m[26:3], m[2], |m[1:0]);
   endfunction

   // float32 a * b; subnormal operands are treated as zero.
   function automatic logic [31:0] fp_mul_f(input logic [31:0] a, input logic [31:0] b);
      logic        s, a_inf, b_inf, a_zero, b_zero;
      logic [47:0] p;
      int          e;
      s      = a[31] ^ b[31];
      a_inf  = (a[30:23] == 8'hFF);
      b_inf  = (b[30:23] == 8'hFF);
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      if ((a_inf && a[22:0] != 23'd0) || (b_inf && b[22:0] != 23'd0)) return FP_QNAN;
      if ((a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47])
         return fp_round_pack(s, e + 1, p[47:24], p[23], |p[22:0]);
      else
         return fp_round_pack(s, e, p[46:23], p[22], |p[21:0]);
   endfunction

endpackage

// File: rtl/FPAdder.sv
// Pipelined float32 adder: result appears LAT cycles after the feeding
// input register was loaded (the input register is owned by the user).
module FPAdder
   import n2_ifft_butterfly_pkg::*;
#(
   parameter int LAT = DEF_ADD_LAT
) (
   input  logic        clk,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] pipe_reg [LAT-1];

   // compute on entry, then shift through the remaining stages
   always_ff @(posedge clk) begin
      pipe_reg[0] <= fp_add_f(a, b);
      for (int i = 1; i < LAT - 1; i++)
         pipe_reg[i] <= pipe_reg[i-1];
   end

   assign y = pipe_reg[LAT-2];

endmodule

// File: rtl/ROM_MUL.sv
// Pipelined float32 multiplier: result appears LAT cycles after the
// feeding input register was loaded.
module ROM_MUL
   import n2_ifft_butterfly_pkg::*;
#(
   parameter int LAT = DEF_MUL_LAT
) (
   input  logic        clk,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] pipe_reg [LAT-1];

   // multiply on entry, then shift through the remaining stages
   always_ff @(posedge clk) begin
      pipe_reg[0] <= fp_mul_f(a, b);
      for (int i = 1; i < LAT - 1; i++)
         pipe_reg[i] <= pipe_reg[i-1];
   end

   assign y = pipe_reg[LAT-2];

endmodule

// File: rtl/SUB.sv
// Pipelined float32 subtractor (a - b), same latency model as FPAdder.
module SUB
   import n2_ifft_butterfly_pkg::*;
#(
   parameter int LAT = DEF_ADD_LAT
) (
   input  logic        clk,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] pipe_reg [LAT-1];

   // subtract by flipping the sign of b, then shift through the stages
   always_ff @(posedge clk) begin
      pipe_reg[0] <= fp_add_f(a, {~b[31], b[30:0]});
      for (int i = 1; i < LAT - 1; i++)
         pipe_reg[i] <= pipe_reg[i-1];
   end

   assign y = pipe_reg[LAT-2];

endmodule

// File: rtl/fp_half.sv
// Exact float32 halving by exponent decrement; Inf/NaN pass through,
// values whose half would leave the normal range flush to signed zero.
module fp_half
   import n2_ifft_butterfly_pkg::*;
(
   input  logic [31:0] a,
   output logic [31:0] y
);

   // decrement the exponent, or pass/flush at the edges of the range
   always_comb begin
      y = a;
      if (a[30:23] == 8'hFF)
         y = a;
      else if (a[30:23] <= 8'd1)
         y = {a[31], FP_ZERO[30:0]};
      else
         y = {a[31], a[30:23] - 8'd1, a[22:0]};
   end

endmodule

// File: rtl/n2_ifft_butterfly.sv
// Radix-2 inverse butterfly: x1 = (F0+F1)/2, x2 = (F0-F1)*conj(W)/2.
// Sequenced over pipelined float cores with a fixed, data-independent
// latency of 2*ADD_LAT+MUL_LAT+2 cycles from the accepting edge.
module n2_ifft_butterfly
   import n2_ifft_butterfly_pkg::*;
#(
   parameter int ADD_LAT = DEF_ADD_LAT,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] f0r,
   input  logic [31:0] f0i,
   input  logic [31:0] f1r,
   input  logic [31:0] f1i,
   input  logic [31:0] cos_w,
   input  logic [31:0] sin_w,
   output logic        busy,
   output logic        done,
   output logic [31:0] x1r,
   output logic [31:0] x1i,
   output logic [31:0] x2r,
   output logic [31:0] x2i
);

   // counter values at which each wait state's cores deliver
   localparam logic [7:0] SD_LAST  = 8'(ADD_LAT - 1);
   localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 2);
   localparam logic [7:0] ADD_CAP  = 8'(ADD_LAT - 2);
   localparam logic [7:0] FIN_LAST = 8'(ADD_LAT - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        sd_last, mul_last, add_cap, fin;

   logic [31:0] f0r_reg, f0i_reg, f1r_reg, f1i_reg, cos_reg, sin_reg;
   logic [31:0] s_re_reg, s_im_reg, d_re_reg, d_im_reg, adder_reg;
   logic [31:0] x1r_reg, x1i_reg, x2r_reg, x2i_reg;
   logic        busy_reg, done_reg;

   // core input registers and outputs, lane 0/1
   logic [31:0] add_a_reg [2];
   logic [31:0] add_b_reg [2];
   logic [31:0] sub_a_reg [2];
   logic [31:0] sub_b_reg [2];
   logic [31:0] mul_a_reg [2];
   logic [31:0] mul_b_reg [2];
   logic [31:0] add_y [2];
   logic [31:0] sub_y [2];
   logic [31:0] mul_y [2];
   logic [31:0] half_in [4];
   logic [31:0] half_out [4];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         FPAdder #(.LAT(ADD_LAT)) u_add (
            .clk(clk), .a(add_a_reg[gi]), .b(add_b_reg[gi]), .y(add_y[gi]));
         SUB #(.LAT(ADD_LAT)) u_sub (
            .clk(clk), .a(sub_a_reg[gi]), .b(sub_b_reg[gi]), .y(sub_y[gi]));
         ROM_MUL #(.LAT(MUL_LAT)) u_mul (
            .clk(clk), .a(mul_a_reg[gi]), .b(mul_b_reg[gi]), .y(mul_y[gi]));
      end
   endgenerate

   // x1 from the captured sum; x2 from the registered adder and live sub1
   assign half_in[0] = s_re_reg;
   assign half_in[1] = s_im_reg;
   assign half_in[2] = adder_reg;
   assign half_in[3] = sub_y[1];

   generate
      for (gi = 0; gi < 4; gi++) begin : g_half
         fp_half u_half (.a(half_in[gi]), .y(half_out[gi]));
      end
   endgenerate

   // state and latency counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // next state, counter and the per-edge load strobes
   always_comb begin
      state_next = state_reg;
      sd_last    = 1'b0;
      mul_last   = 1'b0;
      add_cap    = 1'b0;
      fin        = 1'b0;
      case (state_reg)
         IDLE:      if (start) state_next = SD;
         SD:        state_next = WAIT_SD;
         WAIT_SD:   if (cnt_reg == SD_LAST) begin
                       sd_last    = 1'b1;
                       state_next = MUL2;
                    end
         MUL2:      state_next = WAIT_MUL;
         WAIT_MUL:  if (cnt_reg == MUL_LAST) begin
                       mul_last   = 1'b1;
                       state_next = COMB2;
                    end
         COMB2:     state_next = WAIT_COMB;
         WAIT_COMB: begin
                       if (cnt_reg == ADD_CAP) add_cap = 1'b1;
                       if (cnt_reg == FIN_LAST) begin
                          fin        = 1'b1;
                          state_next = IDLE;
                       end
                    end
         default:   state_next = IDLE;
      endcase
      cnt_next = (state_next != state_reg || state_reg == IDLE) ? 8'd0 : cnt_reg + 8'd1;
   end

   // operand capture, core loading, intermediate capture and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         {f0r_reg, f0i_reg, f1r_reg, f1i_reg, cos_reg, sin_reg} <= '0;
         {s_re_reg, s_im_reg, d_re_reg, d_im_reg, adder_reg}    <= '0;
         {x1r_reg, x1i_reg, x2r_reg, x2i_reg}                   <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            add_a_reg[i] <= FP_ZERO;
            add_b_reg[i] <= FP_ZERO;
            sub_a_reg[i] <= FP_ZERO;
            sub_b_reg[i] <= FP_ZERO;
            mul_a_reg[i] <= FP_ZERO;
            mul_b_reg[i] <= FP_ZERO;
         end
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: if (start) begin
               f0r_reg  <= f0r;
               f0i_reg  <= f0i;
               f1r_reg  <= f1r;
               f1i_reg  <= f1i;
               cos_reg  <= cos_w;
               sin_reg  <= sin_w;
               busy_reg <= 1'b1;
            end
            SD: begin
               add_a_reg[0] <= f0r_reg;
               add_b_reg[0] <= f1r_reg;
               add_a_reg[1] <= f0i_reg;
               add_b_reg[1] <= f1i_reg;
               sub_a_reg[0] <= f0r_reg;
               sub_b_reg[0] <= f1r_reg;
               sub_a_reg[1] <= f0i_reg;
               sub_b_reg[1] <= f1i_reg;
            end
            WAIT_SD: if (sd_last) begin
               s_re_reg     <= add_y[0];
               s_im_reg     <= add_y[1];
               d_re_reg     <= sub_y[0];
               d_im_reg     <= sub_y[1];
               mul_a_reg[0] <= sub_y[0];
               mul_b_reg[0] <= cos_reg;
               mul_a_reg[1] <= sub_y[1];
               mul_b_reg[1] <= sin_reg;
            end
            MUL2: begin
               mul_a_reg[0] <= d_im_reg;
               mul_b_reg[0] <= cos_reg;
               mul_a_reg[1] <= d_re_reg;
               mul_b_reg[1] <= sin_reg;
            end
            WAIT_MUL: if (mul_last) begin
               add_a_reg[1] <= mul_y[0];
               add_b_reg[1] <= mul_y[1];
            end
            COMB2: begin
               sub_a_reg[1] <= mul_y[0];
               sub_b_reg[1] <= mul_y[1];
            end
            WAIT_COMB: begin
               if (add_cap) adder_reg <= add_y[1];
               if (fin) begin
                  x1r_reg  <= half_out[0];
                  x1i_reg  <= half_out[1];
                  x2r_reg  <= half_out[2];
                  x2i_reg  <= half_out[3];
                  done_reg <= 1'b1;
                  busy_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign x1r  = x1r_reg;
   assign x1i  = x1i_reg;
   assign x2r  = x2r_reg;
   assign x2i  = x2i_reg;

endmodule
